// File: rtl/float_pkg.sv
// Shared floating-point definitions for the FPU datapath: float32 field
// widths, the divider state encoding and the divide-by-zero result pattern.
package float_pkg;

  localparam int FP_FLOAT_SIZE = 32;
  localparam int FP_EXP_SIZE   = 8;
  localparam int FP_MANT_SIZE  = 23;
  localparam int FP_BIAS       = 127;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Signed infinity: all-ones exponent, zero mantissa.
  function automatic logic [FP_FLOAT_SIZE-1:0] dbz_result(input logic sign);
    return {sign, {FP_EXP_SIZE{1'b1}}, {FP_MANT_SIZE{1'b0}}};
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: subtract the divisor when it fits,
// emit the quotient bit, then shift the partial remainder left by one.
module div_step #(
  parameter int W = 25
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] div,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W-1:0] diff;

  // Compare, conditionally subtract, shift.
  always_comb begin
    q_bit    = (rem >= div);
    diff     = q_bit ? (rem - div) : rem;
    rem_next = diff << 1;
  end

endmodule

// File: rtl/float_divider.sv
// Multi-cycle divider a/b for normalized floats using restoring division,
// one quotient bit per clock.
// Optional macro FLOAT_DIVIDER_ROUND_EN: one extra guard iteration and
// round-to-nearest-even in NORM; undefined gives truncation.
//
// Handshake: start is sampled only in IDLE (busy=0); the accepted edge
// captures a and b. busy is high from the following cycle through the DONE
// cycle. done is a one-cycle pulse in DONE; out and flags are registered and
// held until the next result overwrites them. start during busy is ignored.
module float_divider
  import float_pkg::*;
#(
  parameter int FLOAT_SIZE    = FP_FLOAT_SIZE,
  parameter int EXPONENT_SIZE = FP_EXP_SIZE,
  parameter int MANTISSA_SIZE = FP_MANT_SIZE,
  parameter int BIAS          = FP_BIAS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FLOAT_SIZE-1:0] a,
  input  logic [FLOAT_SIZE-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [FLOAT_SIZE-1:0] out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact,
  output logic                  div_by_zero,
  output logic [1:0]            state_dbg
);

`ifdef FLOAT_DIVIDER_ROUND_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int M      = MANTISSA_SIZE;
  localparam int E      = EXPONENT_SIZE;
  localparam int ITERS  = M + 2 + G;
  localparam int Q_W    = ITERS;
  localparam int R_W    = M + 2;
  localparam int EW     = E + 2;
  localparam int CNT_W  = $clog2(ITERS + 1);
  localparam logic [EW-1:0] BIAS_W = EW'(BIAS);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [R_W-1:0]     rem_q;
  logic [R_W-1:0]     div_q;
  logic [Q_W-1:0]     q_q;
  logic [EW-1:0]      exp_tmp_q;
  logic               sign_q;
  logic               dbz_q;

  logic [R_W-1:0]     step_rem;
  logic               step_q;

  logic [M-1:0]       norm_mant;
  logic [EW-1:0]      norm_exp;
  logic               norm_inx;

  logic [FLOAT_SIZE-1:0] res;
  logic                  res_ovf;
  logic                  res_unf;
  logic                  res_inx;

  div_step #(.W(R_W)) u_step (
    .rem      (rem_q),
    .div      (div_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

`ifdef FLOAT_DIVIDER_ROUND_EN
  logic [M-1:0]  pre_mant;
  logic          guard;
  logic          sticky;
  logic [EW-1:0] base_exp;
  logic [M:0]    mant_sum;

  // Normalize the quotient, then round to nearest even on guard/sticky/lsb.
  always_comb begin
    if (q_q[Q_W-1]) begin
      pre_mant = q_q[M+1:2];
      guard    = q_q[1];
      sticky   = q_q[0] | (|rem_q);
      base_exp = exp_tmp_q;
    end else begin
      pre_mant = q_q[M:1];
      guard    = q_q[0];
      sticky   = |rem_q;
      base_exp = exp_tmp_q - EW'(1);
    end
    mant_sum  = {1'b0, pre_mant} + (M+1)'(guard & (sticky | pre_mant[0]));
    norm_mant = mant_sum[M-1:0];
    norm_exp  = base_exp + EW'(mant_sum[M]);
    norm_inx  = guard | sticky;
  end
`else
  // Normalize the quotient by truncation; a quotient below 1 costs one exponent.
  always_comb begin
    if (q_q[Q_W-1]) begin
      norm_mant = q_q[M:1];
      norm_exp  = exp_tmp_q;
      norm_inx  = q_q[0] | (|rem_q);
    end else begin
      norm_mant = q_q[M-1:0];
      norm_exp  = exp_tmp_q - EW'(1);
      norm_inx  = |rem_q;
    end
  end
`endif

  // Assemble the result word and flags; a zero divisor overrides everything.
  always_comb begin
    res     = {sign_q, norm_exp[E-1:0], norm_mant};
    res_ovf = norm_exp[E] & ~norm_exp[E+1];
    res_unf = norm_exp[E+1];
    res_inx = norm_inx;
    if (dbz_q) begin
      res     = dbz_result(sign_q);
      res_ovf = 1'b0;
      res_unf = 1'b0;
      res_inx = 1'b0;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      q_q         <= '0;
      exp_tmp_q   <= '0;
      sign_q      <= 1'b0;
      dbz_q       <= 1'b0;
      out         <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      inexact     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_q    <= a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1];
            exp_tmp_q <= {2'b00, a[FLOAT_SIZE-2 -: E]}
                       - {2'b00, b[FLOAT_SIZE-2 -: E]} + BIAS_W;
            rem_q     <= {1'b0, 1'b1, a[M-1:0]};
            div_q     <= {1'b0, 1'b1, b[M-1:0]};
            dbz_q     <= (b[FLOAT_SIZE-2:0] == '0);
            q_q       <= '0;
            cnt_q     <= '0;
            state_q   <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q <= step_rem;
          q_q   <= {q_q[Q_W-2:0], step_q};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITERS - 1)) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          out         <= res;
          overflow    <= res_ovf;
          underflow   <= res_unf;
          inexact     <= res_inx;
          div_by_zero <= dbz_q;
          state_q     <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_float_divider.sv
// Self-checking bench for float_divider: directed cases plus random
// operands, scored against an integer-arithmetic model of a/b.
module tb_float_divider;

`ifdef FLOAT_DIVIDER_ROUND_EN
  localparam int LAT = 27;
`else
  localparam int LAT = 26;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        overflow;
  logic        underflow;
  logic        inexact;
  logic        div_by_zero;
  logic [1:0]  state_dbg;

  logic [35:0] exp_q[$];
  int          acc_q[$];
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  bit          inflight = 0;
  int          busy_gaps = 0;

  float_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .overflow    (overflow),
    .underflow   (underflow),
    .inexact     (inexact),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference: a/b from the real-number definition using integer division
  // of the significands; returns {out, overflow, underflow, inexact, dbz}.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    logic               s;
    int                 e;
    int                 sh;
    longint unsigned    num;
    longint unsigned    den;
    longint unsigned    q;
    longint unsigned    r;
    longint unsigned    qm;
    logic               inx;
    logic [7:0]         ef;
    logic [31:0]        res;
    s = x[31] ^ y[31];
    if (y[30:0] == 31'd0) begin
      res = {s, 8'hFF, 23'd0};
      return {res, 4'b0001};
    end
    num = (64'd1 << 23) | 64'(x[22:0]);
    den = (64'd1 << 23) | 64'(y[22:0]);
    sh  = (num >= den) ? 0 : 1;
    e   = int'(x[30:23]) - int'(y[30:23]) + 127 - sh;
`ifdef FLOAT_DIVIDER_ROUND_EN
    q  = (num << (24 + sh)) / den;
    r  = (num << (24 + sh)) % den;
    qm = q >> 1;
    inx = (q[0] == 1'b1) || (r != 0);
    if (q[0] && ((r != 0) || qm[0])) qm = qm + 1;
    if (qm == (64'd1 << 24)) begin
      qm = qm >> 1;
      e  = e + 1;
    end
`else
    q   = (num << (23 + sh)) / den;
    r   = (num << (23 + sh)) % den;
    qm  = q;
    inx = (r != 0);
`endif
    ef  = e[7:0];
    res = {s, ef, qm[22:0]};
    return {res, (e >= 256), (e < 0), inx, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v);
    wait_idle();
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    @(posedge clk);
    #1;
    exp_q.push_back(model(ta, tb_v));
    acc_q.push_back(cyc);
    busy_gaps = 0;
    inflight  = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Issue an op, then pulse start with junk operands mid-flight and again
  // during the done cycle; neither may be accepted or disturb the result.
  task automatic issue_with_glitch(input logic [31:0] ta, input logic [31:0] tb_v);
    int n;
    issue(ta, tb_v);
    repeat (5) @(negedge clk);
    start = 1'b1;
    a     = 32'h12345678;
    b     = 32'h3F8ABCDE;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("glitch_done_timeout", 64'(done), 64'd1);
    start = 1'b1;
    a     = 32'h40A00000;
    b     = 32'h3F800000;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Abort an op mid-flight with an asynchronous reset, then confirm it
  // produces no result and that the next op completes normally.
  task automatic reset_midop();
    issue(32'h40E00000, 32'h40400000);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_out",   64'(out), 64'd0);
    check("rst_flags", 64'({overflow, underflow, inexact, div_by_zero}), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    exp_q.delete();
    acc_q.delete();
    inflight = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'h40E00000, 32'h40400000);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [35:0] want;
    int          acc;
    #1;
    if (!reset) begin
      if (inflight && !busy) busy_gaps++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          want = exp_q.pop_front();
          acc  = acc_q.pop_front();
          check("result", 64'({out, overflow, underflow, inexact, div_by_zero}), 64'(want));
          check("latency", 64'(cyc - acc), 64'(LAT));
          check("busy_held", 64'(busy_gaps), 64'd0);
          inflight  = 0;
          busy_gaps = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",  64'(busy), 64'd0);
    check("reset_done",  64'(done), 64'd0);
    check("reset_out",   64'(out), 64'd0);
    check("reset_flags", 64'({overflow, underflow, inexact, div_by_zero}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    issue(32'h40C00000, 32'h40000000);
    issue(32'h3F800000, 32'h40400000);
    issue_with_glitch(32'hBFC00000, 32'h3F000000);
    issue(32'h3F800000, 32'h80000000);
    issue(32'h7F000000, 32'h00800000);
    issue(32'h00800000, 32'h7F000000);
    reset_midop();

    for (int i = 0; i < 30; i++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 23'($urandom)};
      if (i % 7 == 3) rb[30:0] = 31'd0;
      if (i % 5 == 2) rb[22:0] = ra[22:0];
      issue(ra, rb);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
